// File: rtl/pc_sequencer_if.sv
// Bus between the control unit / PC register and the next-PC sequencer.
// PC_ALIGN_CHECK_EN adds the align_fault signal.
interface pc_sequencer_if;
   logic [31:0] pc_current;
   logic [31:0] pc_next;
   logic        branch_en;
   logic [31:0] branch_offset;
   logic        jump_en;
   logic [25:0] jump_index;
   logic        jr_en;
   logic [31:0] jr_target;
   logic        stall;
   logic        halt;
   logic        resume;
   logic        irq_req;
   logic        eret;
   logic        irq_ack;
   logic [31:0] epc;
   logic [1:0]  state;
`ifdef PC_ALIGN_CHECK_EN
   logic        align_fault;
`endif

   // Control side: drives the PC and control enables, observes the sequencer.
   modport master (
      output pc_current, branch_en, branch_offset, jump_en, jump_index,
             jr_en, jr_target, stall, halt, resume, irq_req, eret,
`ifdef PC_ALIGN_CHECK_EN
      input  align_fault,
`endif
      input  pc_next, irq_ack, epc, state
   );

   // Sequencer side.
   modport slave (
      input  pc_current, branch_en, branch_offset, jump_en, jump_index,
             jr_en, jr_target, stall, halt, resume, irq_req, eret,
`ifdef PC_ALIGN_CHECK_EN
      output align_fault,
`endif
      output pc_next, irq_ack, epc, state
   );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC controller: PC source select, RUN/HALTED/ISR state machine, EPC and irq_ack.
// Optional PC_ALIGN_CHECK_EN traps misaligned register jumps.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
   parameter int unsigned PC_STEP      = 4
) (
   input logic           clock,
   input logic           reset,
   pc_sequencer_if.slave bus
);
   localparam int unsigned XLEN = 32;

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_HALTED = 2'b01,
      ST_ISR    = 2'b10,
      ST_UNUSED = 2'b11
   } state_t;

   state_t            r_state;
   logic [XLEN-1:0]   r_epc;
   logic              r_irq_ack;

   logic [XLEN-1:0]   w_seq;
   logic [XLEN-1:0]   w_br;
   logic [XLEN-1:0]   w_jmp;
   logic [XLEN-1:0]   w_ns;
   logic [XLEN-1:0]   w_pc_sel;
   logic [XLEN-1:0]   w_epc_val;
   state_t            w_state_nx;
   logic              w_epc_ld;
   logic              w_trap;
   logic              w_fault;
   logic              w_misalign;

   // Candidate targets; all arithmetic wraps at 32 bits.
   assign w_seq = bus.pc_current + XLEN'(PC_STEP);
   assign w_br  = w_seq + (bus.branch_offset << 2);
   assign w_jmp = {w_seq[31:28], bus.jump_index, 2'b00};

   always_comb begin
      if (bus.jr_en)          w_ns = bus.jr_target;
      else if (bus.jump_en)   w_ns = w_jmp;
      else if (bus.branch_en) w_ns = w_br;
      else                    w_ns = w_seq;
   end

`ifdef PC_ALIGN_CHECK_EN
   assign w_misalign = bus.jr_en & (bus.jr_target[1:0] != 2'b00);
`else
   assign w_misalign = 1'b0;
`endif

   // Next-PC, next-state and EPC load decisions.
   always_comb begin
      w_pc_sel   = w_ns;
      w_state_nx = r_state;
      w_epc_ld   = 1'b0;
      w_epc_val  = w_ns;
      w_trap     = 1'b0;
      w_fault    = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (bus.stall) begin
               w_pc_sel = bus.pc_current;
            end else if (bus.irq_req) begin
               w_pc_sel   = TRAP_VECTOR;
               w_epc_ld   = 1'b1;
               w_trap     = 1'b1;
               w_state_nx = ST_ISR;
            end else if (bus.halt) begin
               w_pc_sel   = bus.pc_current;
               w_state_nx = ST_HALTED;
            end else if (w_misalign) begin
               w_pc_sel   = TRAP_VECTOR;
               w_epc_ld   = 1'b1;
               w_epc_val  = bus.pc_current;
               w_fault    = 1'b1;
               w_state_nx = ST_ISR;
            end
         end
         ST_HALTED: begin
            w_pc_sel = bus.pc_current;
            // Trap from HALTED returns past the halt instruction.
            if (bus.irq_req) begin
               w_pc_sel   = TRAP_VECTOR;
               w_epc_ld   = 1'b1;
               w_epc_val  = w_seq;
               w_trap     = 1'b1;
               w_state_nx = ST_ISR;
            end else if (bus.resume) begin
               w_pc_sel   = w_seq;
               w_state_nx = ST_RUN;
            end
         end
         ST_ISR: begin
            if (bus.stall) begin
               w_pc_sel = bus.pc_current;
            end else if (bus.eret) begin
               w_pc_sel   = r_epc;
               w_state_nx = ST_RUN;
            end else if (bus.halt) begin
               w_pc_sel   = bus.pc_current;
               w_state_nx = ST_HALTED;
            end else if (w_misalign) begin
               w_pc_sel  = TRAP_VECTOR;
               w_epc_ld  = 1'b1;
               w_epc_val = bus.pc_current;
               w_fault   = 1'b1;
            end
         end
         default: begin
            w_pc_sel   = bus.pc_current;
            w_state_nx = ST_RUN;
         end
      endcase
   end

   assign bus.pc_next = reset ? RESET_VECTOR : w_pc_sel;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state   <= ST_RUN;
         r_epc     <= '0;
         r_irq_ack <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_irq_ack <= w_trap;
         if (w_epc_ld) r_epc <= w_epc_val;
      end
   end

`ifdef PC_ALIGN_CHECK_EN
   logic r_align_fault;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_align_fault <= 1'b0;
      else       r_align_fault <= w_fault;
   end

   assign bus.align_fault = r_align_fault;
`else
   logic w_fault_unused;
   assign w_fault_unused = w_fault;
`endif

   assign bus.state   = r_state;
   assign bus.epc     = r_epc;
   assign bus.irq_ack = r_irq_ack;
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_pc_sequencer;
   localparam logic [1:0] RUN = 2'b00, HLT = 2'b01, ISR = 2'b10;

   typedef struct {
      string       name;
      logic [31:0] pcn;
      logic [1:0]  st;
      logic [31:0] epc;
      logic        ack;
      logic        flt;
   } exp_t;

   logic clock;
   logic reset;
   pc_sequencer_if bus ();

   pc_sequencer dut (.clock(clock), .reset(reset), .bus(bus));

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
      end
   endtask

   // Monitor: outputs are valid every cycle; compare one queued entry per cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp(e.name, "pc_next", bus.pc_next, e.pcn);
            cmp(e.name, "state", 32'(bus.state), 32'(e.st));
            cmp(e.name, "epc", bus.epc, e.epc);
            cmp(e.name, "irq_ack", 32'(bus.irq_ack), 32'(e.ack));
`ifdef PC_ALIGN_CHECK_EN
            cmp(e.name, "align_fault", 32'(bus.align_fault), 32'(e.flt));
`endif
         end
      end
   end

   task automatic clr();
      bus.branch_en = 1'b0; bus.branch_offset = '0;
      bus.jump_en = 1'b0;   bus.jump_index = '0;
      bus.jr_en = 1'b0;     bus.jr_target = '0;
      bus.stall = 1'b0;     bus.halt = 1'b0;
      bus.resume = 1'b0;    bus.irq_req = 1'b0;
      bus.eret = 1'b0;
   endtask

   // Start a new cycle: just after the rising edge, controls cleared.
   task automatic go(input logic [31:0] pc);
      @(posedge clock);
      #1;
      clr();
      bus.pc_current = pc;
   endtask

   task automatic expect_(input string n, input logic [31:0] pcn, input logic [1:0] st,
                          input logic [31:0] epc, input logic ack, input logic flt = 1'b0);
      exp_t e;
      e.name = n; e.pcn = pcn; e.st = st; e.epc = epc; e.ack = ack; e.flt = flt;
      q.push_back(e);
   endtask

   initial begin
      reset = 1'b1;
      clr();
      bus.pc_current = '0;

      go(32'h1234);                 expect_("reset_hold", 32'h0, RUN, 32'h0, 1'b0);
      go(32'h0); reset = 1'b0;      expect_("seq0", 32'h4, RUN, 32'h0, 1'b0);
      go(32'hFFFF_FFFC);            expect_("wrap", 32'h0, RUN, 32'h0, 1'b0);
      go(32'h100); bus.branch_en = 1'b1; bus.branch_offset = 32'hFFFF_FFFE;
                                    expect_("branch_neg", 32'hFC, RUN, 32'h0, 1'b0);
      go(32'h100); bus.jump_en = 1'b1; bus.branch_en = 1'b1; bus.jump_index = 26'h40;
      bus.branch_offset = 32'h10;   expect_("jump_over_br", 32'h100, RUN, 32'h0, 1'b0);
      go(32'h100); bus.jr_en = 1'b1; bus.jump_en = 1'b1; bus.jr_target = 32'h2000;
      bus.jump_index = 26'h40;      expect_("jr_over_jump", 32'h2000, RUN, 32'h0, 1'b0);

      // Trap over a jump, then ISR with a second irq ignored, then return.
      go(32'h200); bus.jump_en = 1'b1; bus.jump_index = 26'h10; bus.irq_req = 1'b1;
      bus.halt = 1'b1;              expect_("trap", 32'h80, RUN, 32'h0, 1'b0);
      go(32'h80); bus.irq_req = 1'b1;
                                    expect_("isr_irq_ign", 32'h84, ISR, 32'h40, 1'b1);
      go(32'h84);                   expect_("ack_once", 32'h88, ISR, 32'h40, 1'b0);
      go(32'h88); bus.eret = 1'b1;  expect_("eret", 32'h40, ISR, 32'h40, 1'b0);
      go(32'h40); bus.eret = 1'b1;  expect_("eret_run_ign", 32'h44, RUN, 32'h40, 1'b0);

      // Halt, hold with controls ignored, resume.
      go(32'h30); bus.halt = 1'b1;  expect_("halt", 32'h30, RUN, 32'h40, 1'b0);
      for (int i = 0; i < 5; i++) begin
         go(32'h30); bus.jump_en = 1'b1; bus.branch_en = 1'b1; bus.eret = 1'b1;
         bus.jr_en = 1'b1; bus.jr_target = 32'h500;
         expect_("halted_hold", 32'h30, HLT, 32'h40, 1'b0);
      end
      go(32'h30); bus.resume = 1'b1; expect_("resume", 32'h34, HLT, 32'h40, 1'b0);
      go(32'h34);                   expect_("resumed", 32'h38, RUN, 32'h40, 1'b0);

      // irq in HALTED wins over resume; epc returns past the halt.
      go(32'h30); bus.halt = 1'b1;  expect_("halt2", 32'h30, RUN, 32'h40, 1'b0);
      go(32'h30); bus.irq_req = 1'b1; bus.resume = 1'b1;
                                    expect_("halted_irq", 32'h80, HLT, 32'h40, 1'b0);
      go(32'h80);                   expect_("halted_epc", 32'h84, ISR, 32'h34, 1'b1);
      go(32'h84); bus.eret = 1'b1;  expect_("eret2", 32'h34, ISR, 32'h34, 1'b0);
      go(32'h34);                   expect_("run2", 32'h38, RUN, 32'h34, 1'b0);

      // Stall defers the trap.
      for (int i = 0; i < 3; i++) begin
         go(32'h50); bus.stall = 1'b1; bus.irq_req = 1'b1; bus.halt = 1'b1;
         expect_("stall_irq", 32'h50, RUN, 32'h34, 1'b0);
      end
      go(32'h50); bus.irq_req = 1'b1; expect_("stall_release", 32'h80, RUN, 32'h34, 1'b0);
      go(32'h80);                   expect_("trap_after_stall", 32'h84, ISR, 32'h54, 1'b1);
      go(32'h84); bus.eret = 1'b1; bus.irq_req = 1'b1;
                                    expect_("eret_irq_hi", 32'h54, ISR, 32'h54, 1'b0);
      go(32'h54); bus.irq_req = 1'b1; expect_("irq_after_eret", 32'h80, RUN, 32'h54, 1'b0);
      go(32'h80);                   expect_("isr3", 32'h84, ISR, 32'h58, 1'b1);

      // halt inside ISR goes to HALTED and keeps epc.
      go(32'h84); bus.halt = 1'b1;  expect_("isr_halt", 32'h84, ISR, 32'h58, 1'b0);
      go(32'h84); bus.resume = 1'b1; expect_("isr_halted", 32'h88, HLT, 32'h58, 1'b0);
      go(32'h88);                   expect_("run3", 32'h8C, RUN, 32'h58, 1'b0);

`ifdef PC_ALIGN_CHECK_EN
      go(32'h50); bus.jr_en = 1'b1; bus.jr_target = 32'h1002;
                                    expect_("align_trap", 32'h80, RUN, 32'h58, 1'b0, 1'b0);
      go(32'h80);                   expect_("align_isr", 32'h84, ISR, 32'h50, 1'b0, 1'b1);
      go(32'h84); bus.jr_en = 1'b1; bus.jr_target = 32'h3001;
                                    expect_("align_in_isr", 32'h80, ISR, 32'h50, 1'b0, 1'b0);
      go(32'h80); reset = 1'b1;     expect_("reset_in_isr", 32'h0, RUN, 32'h0, 1'b0, 1'b0);
`else
      go(32'h50); bus.jr_en = 1'b1; bus.jr_target = 32'h1002;
                                    expect_("jr_unaligned", 32'h1002, RUN, 32'h58, 1'b0);
      go(32'h100); bus.irq_req = 1'b1; expect_("trap4", 32'h80, RUN, 32'h58, 1'b0);
      go(32'h80); reset = 1'b1;     expect_("reset_in_isr", 32'h0, RUN, 32'h0, 1'b0);
`endif
      go(32'h0); reset = 1'b0;      expect_("post_reset", 32'h4, RUN, 32'h0, 1'b0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
      #1;
      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
